// File: rtl/spi_tensor_loader_pkg.sv
// spi_tensor_loader_pkg: shared FSM states, error codes and header field layout
package spi_tensor_loader_pkg;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TAG = 2'd1;
  localparam logic [1:0] ERR_DIMS = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [3:0] TAG_BASE = 4'hA;
  localparam int TAG_LSB = 24;
  localparam int ROWS_LSB = 12;
  localparam int COLS_LSB = 0;
endpackage

// File: rtl/spi_tensor_loader_spi_slave.sv
// spi_slave: clk-oversampled SPI mode-0 slave, MSB first, one word per W sclk edges
module spi_slave #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sclk,
  input  logic         mosi,
  input  logic         cs_n,
  output logic         miso,
  output logic [W-1:0] rx_data,
  output logic         rx_valid,
  input  logic         rx_ready,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid
);
  localparam int BW = $clog2(W);
  logic [2:0] sclk_q;
  logic [1:0] mosi_q, cs_q;
  logic [BW-1:0] bit_q;
  logic [W-1:0] rx_sh_q, tx_sh_q, rx_data_q, tx_word;
  logic rx_valid_q, rise, fall, active, last_bit;
  assign rise = sclk_q[1] & ~sclk_q[2];
  assign fall = ~sclk_q[1] & sclk_q[2];
  assign active = ~cs_q[1];
  assign last_bit = bit_q == BW'(W - 1);
  assign tx_word = tx_valid ? tx_data : '0;
  assign miso = tx_sh_q[W-1];
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  // Synchronise the SPI pins, shift in on sclk rise, shift out on sclk fall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= '0;
      mosi_q <= '0;
      cs_q <= 2'b11;
      bit_q <= '0;
      rx_sh_q <= '0;
      tx_sh_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
      cs_q <= {cs_q[0], cs_n};
      rx_valid_q <= 1'b0;
      if (!active) begin
        bit_q <= '0;
        tx_sh_q <= tx_word;
      end else begin
        if (rise) begin
          rx_sh_q <= {rx_sh_q[W-2:0], mosi_q[1]};
          bit_q <= last_bit ? '0 : bit_q + BW'(1);
          if (last_bit) begin
            rx_data_q <= {rx_sh_q[W-2:0], mosi_q[1]};
            rx_valid_q <= rx_ready;
          end
        end
        if (fall) tx_sh_q <= bit_q == '0 ? tx_word : {tx_sh_q[W-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/spi_tensor_loader.sv
// spi_tensor_loader: receives header + payload words over SPI and writes matrices into memory slots
module spi_tensor_loader
  import spi_tensor_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_MATS = 2,
  parameter int DIM_W = 12,
  parameter int MAX_ELEMS = 225792,
  parameter int ADDR_W = 18,
  parameter int TIMEOUT_CYC = 65535,
  localparam int SEL_W = NUM_MATS > 1 ? $clog2(NUM_MATS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                cs_n,
  output logic                miso,
  output logic                mem_we,
  output logic [SEL_W-1:0]    mem_sel,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [NUM_MATS-1:0] mat_ready,
  output logic [DIM_W-1:0]    last_rows,
  output logic [DIM_W-1:0]    last_cols,
  output logic                busy,
  output logic                err,
  output logic [1:0]          err_code
);
  localparam int PW = 2 * DIM_W;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  state_e state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d, mem_sel_q, mem_sel_d;
  logic [PW-1:0] total_q, total_d, hdr_prod;
  logic [ADDR_W-1:0] count_q, count_d, mem_addr_q, mem_addr_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rx_data, tx_data;
  logic [NUM_MATS-1:0] mat_ready_q, mat_ready_d;
  logic [DIM_W-1:0] last_rows_q, last_rows_d, last_cols_q, last_cols_d, hdr_rows, hdr_cols;
  logic [1:0] err_code_q, err_code_d;
  logic [3:0] hdr_idx;
  logic mem_we_q, mem_we_d, err_q, err_d, rx_valid, bad_tag, bad_dims, last_elem;
  assign hdr_idx = rx_data[TAG_LSB+:4] - TAG_BASE;
  assign hdr_rows = rx_data[ROWS_LSB+:DIM_W];
  assign hdr_cols = rx_data[COLS_LSB+:DIM_W];
  assign hdr_prod = PW'(hdr_rows) * PW'(hdr_cols);
  assign bad_tag = hdr_idx >= 4'(NUM_MATS);
  assign bad_dims = hdr_rows == '0 || hdr_cols == '0 || hdr_prod > PW'(MAX_ELEMS);
  assign last_elem = PW'(count_q) == total_q - PW'(1);
  assign busy = state_q == ST_LOAD;
  assign tx_data = {err_code_q, busy, {(DATA_W - 3 - NUM_MATS){1'b0}}, mat_ready_q};
  assign mem_we = mem_we_q;
  assign mem_sel = mem_sel_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mat_ready = mat_ready_q;
  assign last_rows = last_rows_q;
  assign last_cols = last_cols_q;
  assign err = err_q;
  assign err_code = err_code_q;
  spi_slave #(.W(DATA_W)) u_spi (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs_n     (cs_n),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (1'b1),
    .tx_data  (tx_data),
    .tx_valid (1'b1)
  );
  // Header decode in IDLE; element writes and idle timeout in LOAD
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    total_d = total_q;
    count_d = count_q;
    to_d = to_q;
    mem_we_d = 1'b0;
    mem_sel_d = mem_sel_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mat_ready_d = mat_ready_q;
    last_rows_d = last_rows_q;
    last_cols_d = last_cols_q;
    err_d = err_q;
    err_code_d = err_code_q;
    if (state_q == ST_IDLE) begin
      if (rx_valid) begin
        if (bad_tag || bad_dims) begin
          err_d = 1'b1;
          err_code_d = bad_tag ? ERR_TAG : ERR_DIMS;
        end else begin
          err_d = 1'b0;
          err_code_d = ERR_NONE;
          slot_d = SEL_W'(hdr_idx);
          mat_ready_d = mat_ready_q & ~(NUM_MATS'(1) << hdr_idx);
          last_rows_d = hdr_rows;
          last_cols_d = hdr_cols;
          total_d = hdr_prod;
          count_d = '0;
          to_d = '0;
          state_d = ST_LOAD;
        end
      end
    end else if (rx_valid) begin
      mem_we_d = 1'b1;
      mem_sel_d = slot_q;
      mem_addr_d = count_q;
      mem_wdata_d = rx_data;
      count_d = count_q + ADDR_W'(1);
      to_d = '0;
      if (last_elem) begin
        mat_ready_d = mat_ready_q | (NUM_MATS'(1) << slot_q);
        state_d = ST_IDLE;
      end
    end else begin
      to_d = to_q + TO_W'(1);
      if (to_d == TO_W'(TIMEOUT_CYC)) begin
        err_d = 1'b1;
        err_code_d = ERR_TIMEOUT;
        state_d = ST_IDLE;
      end
    end
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q <= '0;
      total_q <= '0;
      count_q <= '0;
      to_q <= '0;
      mem_we_q <= 1'b0;
      mem_sel_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mat_ready_q <= '0;
      last_rows_q <= '0;
      last_cols_q <= '0;
      err_q <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      total_q <= total_d;
      count_q <= count_d;
      to_q <= to_d;
      mem_we_q <= mem_we_d;
      mem_sel_q <= mem_sel_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mat_ready_q <= mat_ready_d;
      last_rows_q <= last_rows_d;
      last_cols_q <= last_cols_d;
      err_q <= err_d;
      err_code_q <= err_code_d;
    end
  end
endmodule

// File: doc/spi_tensor_loader.md
SPI_TENSOR_LOADER -- requirements
Module: spi_tensor_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning SPI word width and memory write-data width.
REQ-002 SHALL have parameter NUM_MATS, default 2, range 1..6, meaning the number of matrix slots; the header tag for slot i is 4'hA+i.
REQ-003 SHALL have parameter DIM_W, default 12, meaning the width of each header dimension field.
REQ-004 SHALL have parameter MAX_ELEMS, default 225792, meaning the maximum accepted rows*cols per matrix.
REQ-005 SHALL have parameter ADDR_W, default 18, meaning the memory address width, with 2^ADDR_W >= MAX_ELEMS.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 65535, meaning the idle clk cycles allowed between payload words.
REQ-007 SHALL have ports, one per line:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- sclk, mosi, cs_n  in  1 each  SPI mode-0 slave inputs.
- miso  out  1  SPI slave output.
- mem_we  out  1  one-cycle element write strobe.
- mem_sel  out  $clog2(NUM_MATS)  target slot of the write.
- mem_addr  out  ADDR_W  row-major element index.
- mem_wdata  out  DATA_W  element value.
- mat_ready  out  NUM_MATS  per-slot matrix-complete flag.
- last_rows, last_cols  out  DIM_W each  dimensions of the most recently accepted header.
- busy  out  1  high in LOAD.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 bad tag, 2 bad dims, 3 timeout.

Function
REQ-008 SHALL implement FSM states IDLE and LOAD.
REQ-009 In IDLE, each rx_valid word SHALL be a header: tag [27:24], rows [DIM_W+11:12], cols [11:0]; bits [31:28] are ignored.
REQ-010 A header with tag-4'hA >= NUM_MATS SHALL set err=1 and err_code=1, leave every other output unchanged, and remain in IDLE.
REQ-011 A header with rows==0, cols==0 or rows*cols>MAX_ELEMS SHALL set err=1 and err_code=2 and remain in IDLE; the product SHALL be computed at 2*DIM_W bits.
REQ-012 A valid header SHALL:
- clear err and err_code and clear mat_ready[slot];
- latch last_rows and last_cols;
- zero the element count and timeout counter;
- enter LOAD on the next clk.
REQ-013 In LOAD, each rx_valid word SHALL produce exactly one write with mem_we=1, mem_sel=slot, mem_addr=count and mem_wdata=word, registered one clk after rx_valid.
REQ-014 The write of element rows*cols-1 SHALL assert mat_ready[slot] in the same cycle as its mem_we and return the FSM to IDLE.
REQ-015 In LOAD, the timeout counter SHALL increment on each clk without rx_valid; on reaching TIMEOUT_CYC it SHALL set err=1 and err_code=3, leave mat_ready[slot]=0, and return to IDLE.
REQ-016 rx_valid in the cycle the counter reaches TIMEOUT_CYC SHALL take precedence: the word is written and the counter reset.
REQ-017 The SPI tx path SHALL hold tx_valid=1 with tx_data = {err_code, busy, zero padding, mat_ready}; it is reloaded after each received word.
REQ-018 rx_ready SHALL be constantly 1; the loader never back-pressures the SPI slave.
REQ-019 mem_we SHALL be 0 in every cycle not covered by REQ-013.
REQ-020 mat_ready bits of slots not addressed by a header SHALL never change.

Reset
REQ-021 While rst_n=0 at a clk edge, the FSM SHALL enter IDLE and all of the following SHALL be 0: mem_we, mem_sel, mem_addr, mem_wdata, mat_ready, last_rows, last_cols, busy, err, err_code, count, timeout counter.
REQ-022 A reset during LOAD SHALL abandon the transfer, with no further writes and no mat_ready assertion.
REQ-023 The FSM SHALL be in IDLE on the first clk after rst_n rises.

Structure
REQ-024 A shared package SHALL hold: the FSM state enum, err_code constants, tag base 4'hA, and the header field bit positions.
REQ-025 SHALL instantiate the existing spi_slave as its only sub-module; the datapath and FSM stay in this module.

Verification
REQ-026 Header 0x0A002003, then words 1..6 -> six writes, sel=0, addr 0..5, data 1..6; mat_ready=2'b01 with the sixth write; busy low afterwards.
REQ-027 Load A (2x3), then header 0x0B003002 plus six words -> sel=1 writes; mat_ready=2'b11; a new A header then clears only bit 0.
REQ-028 Header 0x0C001001 with NUM_MATS=2 -> err=1, err_code=1, no writes; a following valid header clears err.
REQ-029 Header 0x0A000005, then 0x0A310121 (784x289) -> err_code=2 both times, FSM stays IDLE.
REQ-030 Valid 4x4 header, 3 words, then silence with TIMEOUT_CYC=100 -> err_code=3 after 100 idle cycles; mat_ready[0]=0; next header accepted.
REQ-031 rst_n low for one clk after 5 of 16 words -> all outputs 0, no further writes; a fresh load then completes normally.
